// File: rtl/adc_capture_ctrl_pkg.sv
// rfsoc_config: shared ADC sample geometry and the capture FSM state encoding
package rfsoc_config;
    localparam int SAMPLE_W = 16;
    localparam int SAMPLES_PER_WORD = 8;
    typedef enum logic [2:0] {
        CAP_IDLE,
        CAP_ARMED,
        CAP_DELAY,
        CAP_CAPTURE,
        CAP_DONE
    } cap_state_t;
endpackage

// File: rtl/adc_capture_out_reg.sv
// adc_capture_out_reg: one-stage AXIS register that flags beats it cannot accept
// Ports: pl_clk/rst clock and sync reset; in_data/in_valid offered beat;
// m_axis_* registered output stream; dropped = offered beat was not loaded.
module adc_capture_out_reg #(
    parameter int DATA_W = 128
) (
    input  logic              pl_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              dropped
);
    logic can_load;
    assign can_load = ~m_axis_tvalid | m_axis_tready;
    assign dropped = in_valid & ~can_load;
    always_ff @(posedge pl_clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata <= '0;
        end else if (in_valid && can_load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata <= in_data;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end
endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: trigger-aligned, length-bounded capture of the ADC beat stream
// Ports: pl_clk/rst clock and sync reset; s_axis_* ADC input (never stalled);
// m_axis_* captured output; start/abort/trig_in/sw_trig control; capture_len and
// trig_delay latched on start; busy/done/overflow/drop_count status.
module adc_capture_ctrl
    import rfsoc_config::*;
#(
    parameter int DATA_W = SAMPLE_W * SAMPLES_PER_WORD,
    parameter int LEN_W = 16
) (
    input  logic              pl_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic              start,
    input  logic              abort,
    input  logic              trig_in,
    input  logic              sw_trig,
    input  logic [LEN_W-1:0]  capture_len,
    input  logic [LEN_W-1:0]  trig_delay,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [LEN_W-1:0]  drop_count
);
    cap_state_t state, state_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt, cap_len_q, trig_delay_q;
    logic trig_in_q, start_ok, trigger, counting, dropped;
    assign s_axis_tready = 1'b1;
    assign busy = state == CAP_ARMED || state == CAP_DELAY || state == CAP_CAPTURE;
    assign start_ok = start && !abort && (state == CAP_IDLE || state == CAP_DONE);
    assign trigger = state == CAP_ARMED && ((trig_in && !trig_in_q) || sw_trig);
    assign counting = s_axis_tvalid && (state == CAP_DELAY || state == CAP_CAPTURE);
    // cnt counts discarded beats in DELAY, then input beats in CAPTURE;
    // it restarts from zero on every state change.
    always_comb begin
        state_nxt = state;
        if (abort)
            state_nxt = CAP_IDLE;
        else if (start_ok)
            state_nxt = (capture_len == '0) ? CAP_DONE : CAP_ARMED;
        else if (trigger)
            state_nxt = (trig_delay_q != '0) ? CAP_DELAY : CAP_CAPTURE;
        else if (state == CAP_DELAY && s_axis_tvalid && cnt == trig_delay_q - 1'b1)
            state_nxt = CAP_CAPTURE;
        else if (state == CAP_CAPTURE && s_axis_tvalid && cnt == cap_len_q - 1'b1)
            state_nxt = CAP_DONE;
        cnt_nxt = (state_nxt != state) ? '0 : counting ? cnt + 1'b1 : cnt;
    end
    always_ff @(posedge pl_clk) begin
        if (rst) begin
            state <= CAP_IDLE;
            cnt <= '0;
            trig_in_q <= 1'b0;
            cap_len_q <= '0;
            trig_delay_q <= '0;
            done <= 1'b0;
            overflow <= 1'b0;
            drop_count <= '0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            trig_in_q <= trig_in;
            if (start_ok) begin
                cap_len_q <= capture_len;
                trig_delay_q <= trig_delay;
            end
            done <= start_ok ? (capture_len == '0)
                             : done | (state == CAP_CAPTURE && state_nxt == CAP_DONE);
            overflow <= start_ok ? 1'b0 : overflow | dropped;
            drop_count <= start_ok ? '0
                        : (dropped && !(&drop_count)) ? drop_count + 1'b1 : drop_count;
        end
    end
    adc_capture_out_reg #(.DATA_W(DATA_W)) u_out_reg (
        .pl_clk(pl_clk),
        .rst(rst),
        .in_data(s_axis_tdata),
        .in_valid(state == CAP_CAPTURE && s_axis_tvalid && !abort),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .dropped(dropped)
    );
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed self-checking bench for adc_capture_ctrl
module tb_adc_capture_ctrl;
    localparam logic [127:0] BASE = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [127:0] INC = {8{16'h8888}};
    logic pl_clk = 1'b0;
    logic rst = 1'b1;
    logic [127:0] s_axis_tdata = '0;
    logic s_axis_tvalid = 1'b0;
    logic s_axis_tready;
    logic [127:0] m_axis_tdata;
    logic m_axis_tvalid;
    logic m_axis_tready = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic trig_in = 1'b0;
    logic sw_trig = 1'b0;
    logic [15:0] capture_len = '0;
    logic [15:0] trig_delay = '0;
    logic busy, done, overflow;
    logic [15:0] drop_count;
    logic [127:0] got_q[$];
    int n_checks = 0;
    int n_fail = 0;
    adc_capture_ctrl dut (
        .pl_clk(pl_clk),
        .rst(rst),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .start(start),
        .abort(abort),
        .trig_in(trig_in),
        .sw_trig(sw_trig),
        .capture_len(capture_len),
        .trig_delay(trig_delay),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .drop_count(drop_count)
    );
    always #5 pl_clk = ~pl_clk;
    always @(posedge pl_clk) if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
    function automatic logic [127:0] beat(int n);
        return BASE + 128'(n) * INC;
    endfunction
    function automatic logic [127:0] got_at(int i);
        return (i < got_q.size()) ? got_q[i] : 'x;
    endfunction
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge pl_clk);
        #1;
    endtask
    task automatic arm(input logic [15:0] len, input logic [15:0] dly);
        capture_len = len;
        trig_delay = dly;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        repeat (2) tick();
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_tready", s_axis_tready, 1);
        rst = 1'b0;
        tick();
        // trig_in edge at beat 2, capture beats 3..6
        arm(4, 0);
        check("t1_busy_after_start", busy, 1);
        for (int n = 0; n <= 6; n++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = beat(n);
            trig_in = (n >= 2);
            tick();
            if (n == 3) check("t1_latency", m_axis_tdata, beat(3));
        end
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        s_axis_tvalid = 1'b0;
        trig_in = 1'b0;
        repeat (2) tick();
        check("t1_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) check("t1_beat", got_at(i), beat(3 + i));
        check("t1_drop_count", drop_count, 0);
        check("t1_overflow", overflow, 0);
        // sw_trig with delay 3: skip beats 1..3, capture 4 and 5
        got_q.delete();
        arm(2, 3);
        check("t2_done_cleared", done, 0);
        for (int n = 0; n <= 5; n++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = beat(n);
            sw_trig = (n == 0);
            tick();
        end
        sw_trig = 1'b0;
        s_axis_tvalid = 1'b0;
        check("t2_done", done, 1);
        repeat (2) tick();
        check("t2_count", got_q.size(), 2);
        check("t2_beat0", got_at(0), beat(4));
        check("t2_beat1", got_at(1), beat(5));
        // backpressure: first captured beat held, three dropped
        got_q.delete();
        m_axis_tready = 1'b0;
        arm(4, 0);
        for (int n = 0; n <= 4; n++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = beat(n);
            sw_trig = (n == 0);
            tick();
        end
        sw_trig = 1'b0;
        s_axis_tvalid = 1'b0;
        check("t3_drop_count", drop_count, 3);
        check("t3_overflow", overflow, 1);
        check("t3_done", done, 1);
        check("t3_held_valid", m_axis_tvalid, 1);
        check("t3_held_data", m_axis_tdata, beat(1));
        m_axis_tready = 1'b1;
        repeat (3) tick();
        check("t3_drain_count", got_q.size(), 1);
        check("t3_drain_data", got_at(0), beat(1));
        check("t3_tvalid_low", m_axis_tvalid, 0);
        // zero-length capture completes immediately
        got_q.delete();
        arm(0, 0);
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        check("t4_overflow_cleared", overflow, 0);
        check("t4_drop_cleared", drop_count, 0);
        for (int n = 0; n < 3; n++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = beat(n);
            sw_trig = 1'b1;
            tick();
            check("t4_busy_stays_low", busy, 0);
            check("t4_tvalid_stays_low", m_axis_tvalid, 0);
        end
        sw_trig = 1'b0;
        s_axis_tvalid = 1'b0;
        // level already high at arm, re-start ignored, abort
        trig_in = 1'b1;
        tick();
        arm(4, 0);
        check("t5_done_cleared", done, 0);
        for (int n = 0; n < 4; n++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = beat(n);
            tick();
        end
        s_axis_tvalid = 1'b0;
        check("t5_still_armed", busy, 1);
        check("t5_no_output", m_axis_tvalid, 0);
        arm(0, 0);
        check("t5_restart_ignored_busy", busy, 1);
        check("t5_restart_ignored_done", done, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_busy", busy, 0);
        check("t5_abort_done", done, 0);
        check("t5_no_beats", got_q.size(), 0);
        trig_in = 1'b0;
        tick();
        // reset in the middle of a capture, then a full 8-beat capture
        arm(8, 0);
        for (int n = 0; n <= 2; n++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = beat(n);
            sw_trig = (n == 0);
            tick();
        end
        sw_trig = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        check("t6_rst_tvalid", m_axis_tvalid, 0);
        check("t6_rst_tdata", m_axis_tdata, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_overflow", overflow, 0);
        check("t6_rst_drop_count", drop_count, 0);
        got_q.delete();
        arm(8, 0);
        for (int n = 20; n <= 28; n++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = beat(n);
            sw_trig = (n == 20);
            tick();
        end
        sw_trig = 1'b0;
        s_axis_tvalid = 1'b0;
        check("t6_done", done, 1);
        repeat (2) tick();
        check("t6_count", got_q.size(), 8);
        for (int i = 0; i < 8; i++) check("t6_beat", got_at(i), beat(21 + i));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
